// File: rtl/game_pkg.sv
// Shared constants and types for the VGA game sprite controllers.
// clog2 sizes the sprite ROM row/col index ports.
package game_pkg;

    localparam int MAX_X = 640;
    localparam int MAX_Y = 480;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE    = 2'd1,
        HIT     = 2'd2,
        RESPAWN = 2'd3
    } obs_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/obstacle_mover_if.sv
// Obstacle controller bus: frame/game inputs, sprite outputs.
// master drives the inputs (game top / bench), slave is the controller.
interface obstacle_mover_if
    import game_pkg::*;
#(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
);

    logic             frame_tick;
    logic             enable;
    logic             dir;
    logic [9:0]       y_x;
    logic [9:0]       y_y;
    logic [9:0]       x;
    logic [9:0]       y;
    logic [9:0]       obs_x;
    logic [9:0]       obs_y;
    logic             obs_on;
    logic [ROW_W-1:0] rom_row;
    logic [COL_W-1:0] rom_col;
    logic             hit;
    logic             passed;
    obs_state_t       state;

    modport master (
        output frame_tick, enable, dir, y_x, y_y, x, y,
        input  obs_x, obs_y, obs_on, rom_row, rom_col,
        input  hit, passed, state
    );

    modport slave (
        input  frame_tick, enable, dir, y_x, y_y, x, y,
        output obs_x, obs_y, obs_on, rom_row, rom_col,
        output hit, passed, state
    );

endinterface

// File: rtl/bbox_overlap.sv
// Combinational axis-aligned bounding-box overlap test.
// Bounds are summed at 11 bits so boxes near the right edge never wrap.
module bbox_overlap #(
    parameter int AW = 16,
    parameter int AH = 16,
    parameter int BW = 16,
    parameter int BH = 16
) (
    input  logic [9:0] ax,
    input  logic [9:0] ay,
    input  logic [9:0] bx,
    input  logic [9:0] by,
    output logic       overlap
);

    logic [10:0] a_r, a_b, b_r, b_b;

    assign a_r = {1'b0, ax} + 11'(AW);
    assign a_b = {1'b0, ay} + 11'(AH);
    assign b_r = {1'b0, bx} + 11'(BW);
    assign b_b = {1'b0, by} + 11'(BH);

    assign overlap = ({1'b0, bx} < a_r) && ({1'b0, ax} < b_r) &&
                     ({1'b0, by} < a_b) && ({1'b0, ay} < b_b);

endmodule

// File: rtl/obstacle_mover.sv
// Horizontal obstacle sprite: stepping, edge wrap, Yoshi collision, hit/respawn.
// Define OBSTACLE_BOB_EN to add a triangular vertical bob to the sprite.
module obstacle_mover
    import game_pkg::*;
#(
    parameter int SPR_W          = 16,
    parameter int SPR_H          = 16,
    parameter int YOSHI_W        = 16,
    parameter int YOSHI_H        = 16,
    parameter int START_X        = 624,
    parameter int START_Y        = 400,
    parameter int SPEED          = 2,
    parameter int TICK_DIV       = 1,
    parameter int HIT_FRAMES     = 32,
    parameter int RESPAWN_FRAMES = 60,
    parameter int BOB_AMP        = 8
) (
    input  logic       clk,
    input  logic       reset,
    obstacle_mover_if.slave bus
);

    localparam int ROW_W = clog2(SPR_H);
    localparam int COL_W = clog2(SPR_W);

    localparam logic [10:0] X_LIM   = 11'(MAX_X - SPR_W);
    localparam logic [10:0] SPD     = 11'(SPEED);
    localparam logic [7:0]  DIV_END = 8'(TICK_DIV - 1);
    localparam logic [7:0]  HIT_END = 8'(HIT_FRAMES - 1);
    localparam logic [7:0]  RSP_END = 8'(RESPAWN_FRAMES - 1);
    localparam logic [9:0]  X0      = 10'(START_X);
    localparam logic [9:0]  Y0      = 10'(START_Y);

    obs_state_t  state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  stp_q, stp_d;
    logic        hit_q, hit_d;
    logic        pass_q, pass_d;
    logic        bob_step;
    logic        bob_clr;
    logic [9:0]  obs_y;
    logic [10:0] x_wide;
    logic [9:0]  x_step;
    logic        wrap;
    logic        overlap;

`ifdef OBSTACLE_BOB_EN
    localparam int PH_W = clog2(2 * BOB_AMP) + 1;
    localparam logic [PH_W-1:0] AMP    = PH_W'(BOB_AMP);
    localparam logic [PH_W-1:0] PERIOD = PH_W'(2 * BOB_AMP);
    localparam logic [PH_W-1:0] PH_END = PH_W'(2 * BOB_AMP - 1);

    logic [PH_W-1:0] ph_q;
    logic [PH_W-1:0] bob;

    // Phase runs 0..2*AMP-1; bob folds it into 0..AMP..0.
    assign bob   = (ph_q <= AMP) ? ph_q : PERIOD - ph_q;
    assign obs_y = Y0 - 10'(bob);

    always_ff @(posedge clk) begin
        if (reset || bob_clr)
            ph_q <= '0;
        else if (bob_step)
            ph_q <= (ph_q == PH_END) ? '0 : ph_q + 1'b1;
    end
`else
    assign obs_y = Y0;
`endif

    bbox_overlap #(
        .AW (SPR_W),
        .AH (SPR_H),
        .BW (YOSHI_W),
        .BH (YOSHI_H)
    ) u_ovl (
        .ax      (x_q),
        .ay      (obs_y),
        .bx      (bus.y_x),
        .by      (bus.y_y),
        .overlap (overlap)
    );

    assign x_wide = {1'b0, x_q};

    always_comb begin
        wrap   = 1'b0;
        x_step = x_q;
        unique case (1'b1)
            !bus.dir: begin
                if (x_wide < SPD) begin
                    wrap   = 1'b1;
                    x_step = 10'(X_LIM);
                end else begin
                    x_step = 10'(x_wide - SPD);
                end
            end
            bus.dir: begin
                if (x_wide + SPD > X_LIM) begin
                    wrap   = 1'b1;
                    x_step = '0;
                end else begin
                    x_step = 10'(x_wide + SPD);
                end
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        stp_d    = stp_q;
        hit_d    = 1'b0;
        pass_d   = 1'b0;
        bob_step = 1'b0;
        bob_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                stp_d = '0;
                if (bus.enable) begin
                    state_d = MOVE;
                    x_d     = X0;
                end
            end
            MOVE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    stp_d   = '0;
                end else if (bus.frame_tick) begin
                    // Collision is judged on the pre-move position and wins.
                    if (overlap) begin
                        state_d = HIT;
                        cnt_d   = '0;
                        stp_d   = '0;
                        hit_d   = 1'b1;
                    end else if (stp_q == DIV_END) begin
                        stp_d    = '0;
                        x_d      = x_step;
                        pass_d   = wrap;
                        bob_step = 1'b1;
                    end else begin
                        stp_d = stp_q + 8'd1;
                    end
                end
            end
            HIT: begin
                if (bus.frame_tick) begin
                    if (cnt_q == HIT_END) begin
                        state_d = RESPAWN;
                        cnt_d   = '0;
                        x_d     = X0;
                        bob_clr = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            RESPAWN: begin
                if (bus.frame_tick) begin
                    if (cnt_q == RSP_END) begin
                        state_d = bus.enable ? MOVE : IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= X0;
            cnt_q   <= '0;
            stp_q   <= '0;
            hit_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            stp_q   <= stp_d;
            hit_q   <= hit_d;
            pass_q  <= pass_d;
        end
    end

    logic [10:0] px, py;
    logic        in_x, in_y, visible;

    assign px   = {1'b0, bus.x};
    assign py   = {1'b0, bus.y};
    assign in_x = (px >= x_wide) && (px < x_wide + 11'(SPR_W));
    assign in_y = (py >= {1'b0, obs_y}) &&
                  (py < {1'b0, obs_y} + 11'(SPR_H));
    // Flash while hit: sprite shown on frames whose counter bit 2 is clear.
    assign visible = (state_q == MOVE) ||
                     ((state_q == HIT) && !cnt_q[2]);

    assign bus.obs_on  = in_x && in_y && visible;
    assign bus.rom_col = COL_W'(bus.x - x_q);
    assign bus.rom_row = ROW_W'(bus.y - obs_y);
    assign bus.obs_x   = x_q;
    assign bus.obs_y   = obs_y;
    assign bus.hit     = hit_q;
    assign bus.passed  = pass_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_obstacle_mover.sv
// Bench for obstacle_mover: two instances (TICK_DIV 1 and 3) against a
// frame-level model, plus directed literal checks on positions and pulses.
module tb_obstacle_mover;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic tick, en, dir;
    int   yx, yy, px, py;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    obstacle_mover_if #(.ROW_W(4), .COL_W(4)) ia ();
    obstacle_mover_if #(.ROW_W(4), .COL_W(4)) ib ();

    assign ia.frame_tick = tick;
    assign ia.enable     = en;
    assign ia.dir        = dir;
    assign ia.y_x        = 10'(yx);
    assign ia.y_y        = 10'(yy);
    assign ia.x          = 10'(px);
    assign ia.y          = 10'(py);
    assign ib.frame_tick = tick;
    assign ib.enable     = en;
    assign ib.dir        = dir;
    assign ib.y_x        = 10'(yx);
    assign ib.y_y        = 10'(yy);
    assign ib.x          = 10'(px);
    assign ib.y          = 10'(py);

    obstacle_mover #(.TICK_DIV(1)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (ia.slave)
    );

    obstacle_mover #(.TICK_DIV(3)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (ib.slave)
    );

    task automatic chk(input string n, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask

    // Model: 0 idle, 1 moving, 2 hit, 3 respawn; positions as plain ints.
    int m_st[2], m_x[2], m_stp[2], m_fr[2], m_bob[2];
    int m_hit[2], m_pas[2];
    int tdiv[2] = '{1, 3};

    function automatic int model_oy(input int k);
`ifdef OBSTACLE_BOB_EN
        int n;
        n = m_bob[k];
        return 400 - ((n <= 8) ? n : 16 - n);
`else
        return 400 + 0 * k;
`endif
    endfunction

    task automatic model_step(input int k);
        int oy;
        bit ov;
        oy = model_oy(k);
        if (rst) begin
            m_st[k] = 0; m_x[k] = 624; m_stp[k] = 0;
            m_fr[k] = 0; m_bob[k] = 0; m_hit[k] = 0; m_pas[k] = 0;
            return;
        end
        m_hit[k] = 0;
        m_pas[k] = 0;
        case (m_st[k])
            0: begin
                m_stp[k] = 0;
                if (en) begin m_st[k] = 1; m_x[k] = 624; end
            end
            1: begin
                if (!en) begin
                    m_st[k] = 0; m_stp[k] = 0;
                end else if (tick) begin
                    ov = yx < m_x[k] + 16 && m_x[k] < yx + 16 &&
                         yy < oy + 16 && oy < yy + 16;
                    if (ov) begin
                        m_st[k] = 2; m_fr[k] = 0; m_hit[k] = 1; m_stp[k] = 0;
                    end else begin
                        m_stp[k]++;
                        if (m_stp[k] == tdiv[k]) begin
                            m_stp[k] = 0;
                            m_bob[k] = (m_bob[k] + 1) % 16;
                            if (!dir) begin
                                if (m_x[k] < 2) begin m_x[k] = 624; m_pas[k] = 1; end
                                else m_x[k] -= 2;
                            end else begin
                                if (m_x[k] + 2 > 624) begin m_x[k] = 0; m_pas[k] = 1; end
                                else m_x[k] += 2;
                            end
                        end
                    end
                end
            end
            2: if (tick) begin
                m_fr[k]++;
                if (m_fr[k] == 32) begin
                    m_st[k] = 3; m_fr[k] = 0; m_x[k] = 624; m_bob[k] = 0;
                end
            end
            default: if (tick) begin
                m_fr[k]++;
                if (m_fr[k] == 60) begin
                    m_st[k] = en ? 1 : 0; m_fr[k] = 0;
                end
            end
        endcase
    endtask

    task automatic cmp(input int k, input int st, input int x, input int y,
                       input int on, input int row, input int col,
                       input int h, input int p);
        int oy, eon;
        bit vis;
        oy  = model_oy(k);
        vis = m_st[k] == 1 || (m_st[k] == 2 && ((m_fr[k] >> 2) & 1) == 0);
        eon = (vis && px >= m_x[k] && px < m_x[k] + 16 &&
               py >= oy && py < oy + 16) ? 1 : 0;
        chk($sformatf("cyc%0d state", k), st, m_st[k]);
        chk($sformatf("cyc%0d obs_x", k), x, m_x[k]);
        chk($sformatf("cyc%0d obs_y", k), y, oy);
        chk($sformatf("cyc%0d obs_on", k), on, eon);
        chk($sformatf("cyc%0d hit", k), h, m_hit[k]);
        chk($sformatf("cyc%0d passed", k), p, m_pas[k]);
        if (eon == 1) begin
            chk($sformatf("cyc%0d rom_row", k), row, (py - oy) & 15);
            chk($sformatf("cyc%0d rom_col", k), col, (px - m_x[k]) & 15);
        end
    endtask

    always begin
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cmp(0, int'(ia.state), int'(ia.obs_x), int'(ia.obs_y), int'(ia.obs_on),
            int'(ia.rom_row), int'(ia.rom_col), int'(ia.hit), int'(ia.passed));
        cmp(1, int'(ib.state), int'(ib.obs_x), int'(ib.obs_y), int'(ib.obs_on),
            int'(ib.rom_row), int'(ib.rom_col), int'(ib.hit), int'(ib.passed));
    end

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; tick = 1'b0;
        yx = 0; yy = 0; px = 624; py = 400;
        repeat (2) @(negedge clk);
        chk("reset state", int'(ia.state), 0);
        chk("reset obs_x", int'(ia.obs_x), 624);
        chk("reset obs_y", int'(ia.obs_y), 400);
        chk("reset hit", int'(ia.hit), 0);
        chk("reset passed", int'(ia.passed), 0);
        chk("reset obs_on", int'(ia.obs_on), 0);

        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        chk("enter move", int'(ia.state), 1);
        chk("enter move x", int'(ia.obs_x), 624);
        tick_n(9);
        chk("A 9 ticks", int'(ia.obs_x), 606);
        chk("B 9 ticks div3", int'(ib.obs_x), 618);
        tick_n(1);
        chk("A 10 ticks", int'(ia.obs_x), 604);
        chk("B 10 ticks div3", int'(ib.obs_x), 618);
        px = 604; py = 400; #1;
        chk("on at corner", int'(ia.obs_on), 1);
        px = 620; #1;
        chk("on right edge", int'(ia.obs_on), 0);
        px = 619; py = 415; #1;
        chk("on far corner", int'(ia.obs_on), 1);
        chk("rom_col 15", int'(ia.rom_col), 15);
        chk("rom_row 15", int'(ia.rom_row), 15);
        py = 416; #1;
        chk("on below", int'(ia.obs_on), 0);

        tick_n(152);
        chk("A at 300", int'(ia.obs_x), 300);
        chk("B 162 ticks", int'(ib.obs_x), 516);
        @(negedge clk) begin rst = 1'b1; px = 300; py = 400; end
        @(negedge clk);
        chk("midmove rst state", int'(ia.state), 0);
        chk("midmove rst x", int'(ia.obs_x), 624);
        chk("midmove rst hit", int'(ia.hit), 0);
        chk("midmove rst on", int'(ia.obs_on), 0);
        chk("midmove rst B x", int'(ib.obs_x), 624);
        rst = 1'b0;
        @(negedge clk);
        chk("rst release move", int'(ia.state), 1);

        tick_n(312);
        chk("A left at 0", int'(ia.obs_x), 0);
        chk("A no pass at 0", int'(ia.passed), 0);
        chk("B 312 ticks", int'(ib.obs_x), 416);
        tick_n(1);
        chk("left wrap x", int'(ia.obs_x), 624);
        chk("left wrap pass", int'(ia.passed), 1);
        @(negedge clk);
        chk("pass one cycle", int'(ia.passed), 0);
        dir = 1'b1;
        tick_n(1);
        chk("right wrap x", int'(ia.obs_x), 0);
        chk("right wrap pass", int'(ia.passed), 1);
        tick_n(311);
        chk("right at 622", int'(ia.obs_x), 622);
        tick_n(1);
        chk("right at limit", int'(ia.obs_x), 624);
        chk("right limit no pass", int'(ia.passed), 0);
        tick_n(1);
        chk("right wrap2 x", int'(ia.obs_x), 0);
        chk("right wrap2 pass", int'(ia.passed), 1);

        dir = 1'b0;
        tick_n(11);
        chk("back to 604", int'(ia.obs_x), 604);
        yx = 610; yy = 395;
        @(negedge clk);
        chk("no tick no hit", int'(ia.state), 1);
        tick_n(1);
        chk("hit state", int'(ia.state), 2);
        chk("hit pulse", int'(ia.hit), 1);
        chk("hit frozen x", int'(ia.obs_x), 604);
        @(negedge clk) en = 1'b0;
        chk("hit one cycle", int'(ia.hit), 0);
        px = 604; py = 400;
        tick_n(8);
        chk("flash on", int'(ia.obs_on), 1);
        tick_n(4);
        chk("flash off", int'(ia.obs_on), 0);
        tick_n(19);
        chk("hit holds en=0", int'(ia.state), 2);
        chk("hit x frozen", int'(ia.obs_x), 604);
        px = 624;
        tick_n(1);
        chk("respawn state", int'(ia.state), 3);
        chk("respawn x", int'(ia.obs_x), 624);
        chk("respawn on", int'(ia.obs_on), 0);
        tick_n(59);
        chk("respawn holds", int'(ia.state), 3);
        tick_n(1);
        chk("respawn to idle", int'(ia.state), 0);

        yx = 0; yy = 0; en = 1'b1;
        @(negedge clk);
        chk("idle to move", int'(ia.state), 1);
        tick_n(1);
        chk("move 622", int'(ia.obs_x), 622);
        en = 1'b0;
        @(negedge clk);
        chk("move to idle", int'(ia.state), 0);
        chk("idle holds x", int'(ia.obs_x), 622);
        en = 1'b1; yx = 610; yy = 395;
        @(negedge clk);
        tick_n(1);
        chk("hit at spawn", int'(ia.state), 2);
        yx = 0; yy = 0;
        tick_n(32);
        chk("respawn 2", int'(ia.state), 3);
        tick_n(60);
        chk("respawn to move", int'(ia.state), 1);
        chk("respawn pos x", int'(ia.obs_x), 624);
        chk("respawn pos y", int'(ia.obs_y), 400);
        py = 400; #1;
        chk("respawn visible", int'(ia.obs_on), 1);

`ifdef OBSTACLE_BOB_EN
        tick_n(8);
        chk("bob peak y", int'(ia.obs_y), 392);
        chk("bob peak x", int'(ia.obs_x), 608);
        tick_n(8);
        chk("bob back y", int'(ia.obs_y), 400);
        tick_n(8);
        chk("bob peak2 y", int'(ia.obs_y), 392);
        yx = 576; yy = 380;
        tick_n(1);
        chk("bob collide", int'(ia.state), 2);
`else
        tick_n(16);
        chk("flat y", int'(ia.obs_y), 400);
        chk("flat x", int'(ia.obs_x), 592);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
